// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Round-robin arbiter that lets N_INP valid/ready requester streams share
//   one output stream. The datapath is purely combinational, so a beat can
//   pass through in the same cycle it is presented. Only two things are
//   registered: the round-robin pointer, and an optional grant lock. The lock
//   keeps the selected input (and therefore the output payload) stable while
//   a granted beat waits for oup_ready_i.
//
// Parameters
//   N_INP       number of input streams (>= 1)
//   DATA_WIDTH  payload width per stream
//   LOCK_IN     1: hold the grant while the output stalls; 0: re-arbitrate every cycle
//   IDX_WIDTH   width of the grant index (derived from N_INP, leave at default)
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   flush_i      synchronous clear of the pointer and the lock
//   inp_data_i   payloads; stream i occupies [i*DATA_WIDTH +: DATA_WIDTH]
//   inp_valid_i  per-input valid
//   inp_ready_o  per-input ready (one-hot or all zero)
//   oup_data_o   payload of the granted input
//   oup_valid_o  output valid
//   oup_ready_i  output ready
//   idx_o        index of the granted input
module stream_rr_arbiter #(
    parameter int unsigned N_INP      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOCK_IN    = 1,
    parameter int unsigned IDX_WIDTH  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
    input  logic [N_INP-1:0]            inp_valid_i,
    output logic [N_INP-1:0]            inp_ready_o,
    output logic [DATA_WIDTH-1:0]       oup_data_o,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    output logic [IDX_WIDTH-1:0]        idx_o
);

    // Highest-priority index for the next unlocked arbitration.
    logic [IDX_WIDTH-1:0] rr_q;
    // Grant lock: set when a granted beat stalls, cleared on its handshake.
    logic                 lock_q;
    logic [IDX_WIDTH-1:0] lock_idx_q;

    logic [IDX_WIDTH-1:0] arb_sel;
    logic                 arb_found;
    logic [IDX_WIDTH-1:0] sel;
    logic [IDX_WIDTH-1:0] rr_next;
    logic                 handshake;
    logic                 stall;

    // Scan inputs starting at rr_q and wrapping modulo N_INP; the first valid
    // one wins. With nothing valid the pointer itself is reported.
    always_comb begin
        int unsigned          cand;
        logic [IDX_WIDTH-1:0] cand_idx;
        arb_sel   = rr_q;
        arb_found = 1'b0;
        for (int unsigned k = 0; k < N_INP; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= N_INP) begin
                cand = cand - N_INP;
            end
            cand_idx = IDX_WIDTH'(cand);
            if (!arb_found && inp_valid_i[cand_idx]) begin
                arb_sel   = cand_idx;
                arb_found = 1'b1;
            end
        end
    end

    // While locked, the stalled input keeps the output even if it drops
    // valid; that is a protocol violation by the requester and is simply
    // reflected on oup_valid_o.
    always_comb begin
        if (lock_q) begin
            sel         = lock_idx_q;
            oup_valid_o = inp_valid_i[lock_idx_q];
        end else begin
            sel         = arb_sel;
            oup_valid_o = arb_found;
        end
    end

    assign idx_o     = sel;
    assign handshake = oup_valid_o & oup_ready_i;
    assign stall     = oup_valid_o & ~oup_ready_i;

    // Payload mux and one-hot ready, decoded by comparison so that a
    // non-power-of-two N_INP never indexes past the last stream.
    always_comb begin
        oup_data_o  = '0;
        inp_ready_o = '0;
        for (int unsigned i = 0; i < N_INP; i++) begin
            if (sel == IDX_WIDTH'(i)) begin
                oup_data_o     = inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                inp_ready_o[i] = handshake;
            end
        end
    end

    // Pointer moves to the input after the one just served.
    always_comb begin
        if (sel == IDX_WIDTH'(N_INP - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = sel + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
        end else if (handshake) begin
            rr_q   <= rr_next;
            lock_q <= 1'b0;
        end else if (stall && (LOCK_IN != 0)) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Testbench for stream_rr_arbiter.
//   Two 4-input instances (LOCK_IN=1 and LOCK_IN=0) see identical stimulus,
//   plus a 1-input instance that must act as a plain wire. A behavioural
//   model tracks each 4-input instance and is compared on every negedge;
//   directed sequences add hand-computed literal grant expectations.
module tb_stream_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N*DW-1:0] inp_data;
    logic [N-1:0]    inp_valid;
    logic            oup_ready;

    logic [N-1:0]    rdy_lk, rdy_nl;
    logic [DW-1:0]   dat_lk, dat_nl;
    logic            val_lk, val_nl;
    logic [1:0]      idx_lk, idx_nl;

    logic [0:0]      rdy_one;
    logic [7:0]      dat_one;
    logic            val_one;
    logic [0:0]      idx_one;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N_INP(N), .DATA_WIDTH(DW), .LOCK_IN(1)) dut_lk (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .inp_data_i(inp_data), .inp_valid_i(inp_valid), .inp_ready_o(rdy_lk),
        .oup_data_o(dat_lk), .oup_valid_o(val_lk), .oup_ready_i(oup_ready),
        .idx_o(idx_lk)
    );

    stream_rr_arbiter #(.N_INP(N), .DATA_WIDTH(DW), .LOCK_IN(0)) dut_nl (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .inp_data_i(inp_data), .inp_valid_i(inp_valid), .inp_ready_o(rdy_nl),
        .oup_data_o(dat_nl), .oup_valid_o(val_nl), .oup_ready_i(oup_ready),
        .idx_o(idx_nl)
    );

    stream_rr_arbiter #(.N_INP(1), .DATA_WIDTH(8), .LOCK_IN(1)) dut_one (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .inp_data_i(inp_data[7:0]), .inp_valid_i(inp_valid[0:0]), .inp_ready_o(rdy_one),
        .oup_data_o(dat_one), .oup_valid_o(val_one), .oup_ready_i(oup_ready),
        .idx_o(idx_one)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0: locking, 1: non-locking)
    int unsigned m_rr   [2];
    bit          m_lock [2];
    int unsigned m_lidx [2];

    function automatic int unsigned m_sel(input int d);
        int unsigned c;
        if (m_lock[d]) return m_lidx[d];
        for (int k = 0; k < N; k++) begin
            c = (m_rr[d] + k) % N;
            if (inp_valid[c[1:0]]) return c;
        end
        return m_rr[d];
    endfunction

    function automatic bit m_valid(input int d);
        int unsigned s;
        s = m_sel(d);
        if (m_lock[d]) return inp_valid[s[1:0]];
        return |inp_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int unsigned s;
        bit v;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_rr[d] = 0; m_lock[d] = 0; m_lidx[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                s = m_sel(d);
                v = m_valid(d);
                if (flush) begin
                    m_rr[d] = 0; m_lock[d] = 0;
                end else if (v && oup_ready) begin
                    m_rr[d] = (s + 1) % N; m_lock[d] = 0;
                end else if (v && d == 0) begin
                    m_lock[d] = 1; m_lidx[d] = s;
                end
            end
        end
    end

    task automatic cmp_dut(input int d, input string tag, input logic [1:0] idx,
                           input logic val, input logic [N-1:0] rdy, input logic [DW-1:0] dat);
        int unsigned s;
        bit v;
        logic [N-1:0] er;
        s  = m_sel(d);
        v  = m_valid(d);
        er = (v && oup_ready) ? (N'(1) << s) : '0;
        chk({tag, "_idx"},   32'(idx), s);
        chk({tag, "_valid"}, 32'(val), 32'(v));
        chk({tag, "_ready"}, 32'(rdy), 32'(er));
        chk({tag, "_data"},  dat, inp_data[s*DW +: DW]);
    endtask

    always @(negedge clk) begin
        cmp_dut(0, "mdl_lk", idx_lk, val_lk, rdy_lk, dat_lk);
        cmp_dut(1, "mdl_nl", idx_nl, val_nl, rdy_nl, dat_nl);
        chk("one_idx",   32'(idx_one), 0);
        chk("one_valid", 32'(val_one), 32'(inp_valid[0]));
        chk("one_ready", 32'(rdy_one), 32'(oup_ready & inp_valid[0]));
        chk("one_data",  32'(dat_one), 32'(inp_data[7:0]));
    end

    // ---------------- directed cycle with literal grant expectations
    task automatic cyc(input logic [N-1:0] v, input logic r, input logic f,
                       input int e_lk, input int e_nl);
        inp_valid = v;
        oup_ready = r;
        flush     = f;
        @(negedge clk);
        chk("lit_idx_lk",   32'(idx_lk), e_lk);
        chk("lit_idx_nl",   32'(idx_nl), e_nl);
        chk("lit_rdy_lk",   32'(rdy_lk), r ? (32'd1 << e_lk) : 32'd0);
        chk("lit_rdy_nl",   32'(rdy_nl), r ? (32'd1 << e_nl) : 32'd0);
        chk("lit_data_lk",  dat_lk, inp_data[e_lk*DW +: DW]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        inp_valid = '0;
        oup_ready = 1'b0;
        for (int i = 0; i < N; i++) inp_data[i*DW +: DW] = 32'hC0DE_0000 + 32'(i) * 32'h111;

        // reset state
        @(negedge clk);
        chk("rst_idx",   32'(idx_lk), 0);
        chk("rst_valid", 32'(val_lk), 0);
        chk("rst_ready", 32'(rdy_lk), 0);
        chk("rst_data",  dat_lk, 32'hC0DE_0000);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all valid, ready: strict rotation
        for (int k = 0; k < 8; k++) cyc(4'b1111, 1'b1, 1'b0, k % 4, k % 4);

        // only inputs 1 and 3
        for (int k = 0; k < 4; k++) cyc(4'b1010, 1'b1, 1'b0, (k % 2) ? 3 : 1, (k % 2) ? 3 : 1);

        // stall on input 2, input 0 joins; locking instance holds 2
        cyc(4'b0100, 1'b0, 1'b0, 2, 2);
        cyc(4'b0101, 1'b0, 1'b0, 2, 0);
        cyc(4'b0101, 1'b0, 1'b0, 2, 0);
        cyc(4'b0101, 1'b1, 1'b0, 2, 0);
        cyc(4'b0101, 1'b1, 1'b0, 0, 2);

        // lock on 3, then flush
        cyc(4'b1000, 1'b0, 1'b0, 3, 3);
        cyc(4'b1111, 1'b0, 1'b1, 3, 3);
        cyc(4'b1111, 1'b1, 1'b0, 0, 0);

        // stall on input 1, then async reset mid-cycle
        cyc(4'b0010, 1'b0, 1'b0, 1, 1);
        inp_valid = 4'b0111;
        oup_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_idx_lk", 32'(idx_lk), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_idx_lk",   32'(idx_lk), 0);
        chk("async_rst_idx_nl",   32'(idx_nl), 0);
        chk("async_rst_valid_lk", 32'(val_lk), 1);
        chk("async_rst_data_lk",  dat_lk, 32'hC0DE_0000);
        @(posedge clk);
        #1;
        inp_valid = 4'b0110;
        oup_ready = 1'b1;
        #1 rst_n = 1'b1;
        cyc(4'b0110, 1'b1, 1'b0, 1, 1);
        cyc(4'b0110, 1'b1, 1'b0, 2, 2);

        // idle: nothing valid
        inp_valid = '0;
        @(negedge clk);
        chk("idle_valid_lk", 32'(val_lk), 0);
        chk("idle_ready_lk", 32'(rdy_lk), 0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
